ex_mc_stage: RTL and testbench
==============================

// Module: ex_mc_stage
// PURPOSE
//  Multi-cycle execute stage, next generation of the single-cycle EX: same ALU/branch/memory paths plus an
//  iterative RV M-extension unit (MUL/MULH/MULHSU/MULHU, DIV/DIVU/REM/REMU). Sits between id_ex_reg and
//  ex_mem_reg; raises ex_busy_o so fc stalls IF/ID/ID-EX while a multi-cycle op runs.
// PARAMETERS
//  XLEN          32  datapath width (operands, results, addresses)
//  MUL_BITS_CYC  4   multiplier bits retired per cycle; must divide XLEN; MUL latency N_MUL = XLEN/MUL_BITS_CYC
// PORTS
//  clk                  in   1     clock; all state updates on posedge
//  rst_n                in   1     reset, asynchronous, active-low
//  idex_valid_i         in   1     valid instruction present in ID/EX
//  idex_op_a_i/op_b_i   in   XLEN  operands
//  idex_ALUctrl_i       in   5     op code (`define codes in define.v)
//  idex_reg_waddr_i     in   5     rd; idex_reg_we_i in 1: rd write enable
//  idex_btype_flag_i    in   1     branch inst; idex_btype_jump_pc_i in XLEN: taken target
//  idex_mtype_i, idex_mem_rw_i (1), idex_mem_width_i (2), idex_mem_wr_data_i (XLEN)  load/store controls
//  fc_stall_ex_i        in   1     hold EX outputs; must not depend combinationally on ex_busy_o
//  fc_flush_ex_i        in   1     kill instruction in EX (incl. in-flight MDU op)
//  ex_valid_o           out  1     result valid this cycle
//  ex_busy_o            out  1     to fc: EX occupied by MDU op, stall upstream
//  ex_reg_wdata_o       out  XLEN  rd result; ex_reg_waddr_o out 5; ex_reg_we_o out 1 (= valid & we)
//  ex_branch_flag_o     out  1     taken branch; ex_branch_pc_o out XLEN target
//  ex_req_Dcache_o      out  1     Dcache request; ex_mem_addr_o out XLEN; ex_mem_rw_o/width/wr_data pass-through
//  ex_illegal_o         out  1     unsupported op (EX_DIV_EN off only)
// BEHAVIOUR
//  - States IDLE, MUL, DIV, DONE. Reset: state IDLE, counter/acc/operand/result regs 0; every valid/req/flag/we
//    output 0 while idex_valid_i=0 in IDLE.
//  - ALU ops (ADD..NO_OP, existing semantics, NAND = ~(a&b)): combinational, ex_valid_o = idex_valid_i in IDLE,
//    zero extra latency. Branch flag = valid & btype & (result!=0). mem addr = ALU result.
//  - ex_req_Dcache_o = IDLE & idex_valid_i & mtype & !fc_stall_ex_i & !fc_flush_ex_i.
//  - Accept MDU op: IDLE & valid & !stall & !flush at cycle T -> latch a, b, op, waddr, we; goto MUL or DIV.
//    ex_busy_o = (MUL|DIV) | (IDLE & valid & MDU op & !special-case).
//  - MUL: shift-add on |a|,|b| per signedness, MUL_BITS_CYC bits/cycle, 2*XLEN accumulator; N_MUL cycles, then
//    DONE at T+N_MUL+1. MUL -> low half; MULH/MULHSU/MULHU -> high half after sign fix.
//  - DIV: restoring, 1 bit/cycle on magnitudes, XLEN cycles, DONE at T+XLEN+1; quotient sign = sa^sb,
//    remainder sign = sa (fixed in DONE).
//  - Special cases complete combinationally in IDLE, no busy: divisor 0 -> q = all-ones, r = a;
//    signed overflow (a = 1<<(XLEN-1), b = -1) -> q = a, r = 0.
//  - DONE: ex_valid_o=1, outputs from latched result; holds while fc_stall_ex_i=1; stall low -> IDLE next cycle.
//    ex_busy_o=0 in DONE so ID/EX advances the same edge.
//  - fc_flush_ex_i in MUL/DIV/DONE -> IDLE next edge, no ex_valid_o; flush beats stall. Async reset mid-op
//    clears all state immediately; no partial result ever emitted.
//  - All arithmetic modulo 2^XLEN; shifts use op_b[$clog2(XLEN)-1:0].
// CONFIGURATION
//  EX_DIV_EN defined: DIV/DIVU/REM/REMU executed as above. Undefined: divider and DIV state not built; those ops
//  complete in IDLE same cycle with ex_illegal_o=1, ex_reg_we_o=0, ex_reg_wdata_o=0; MUL unaffected.
// STRUCTURE
//  - define.v gains `MUL `MULH `MULHSU `MULHU `DIV `DIVU `REM `REMU ALUctrl codes and EX state encodings.
//  - Sub-module ex_mdu: iterative mul/div datapath with start/flush/done handshake; ex_mc_stage keeps FSM-facing
//    muxing, ALU, branch and memory paths.
// TESTING
//  1. ADD a=5 b=7 valid, no stall -> same cycle ex_valid_o=1, wdata=12, busy=0.
//  2. MULHU 0xFFFFFFFF*0xFFFFFFFF -> busy 8 cycles, DONE at T+9 wdata=0xFFFFFFFE; MUL same operands -> 0x00000001.
//  3. DIV -7/2 -> DONE at T+33 wdata=0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14.
//  4. DIV 10/0 -> same cycle 0xFFFFFFFF, REM 10/0 -> 10; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
//  5. MUL accepted, fc_flush_ex_i at T+3 -> no ex_valid_o, IDLE at T+4, following ADD accepted normally.
//  6. DONE with fc_stall_ex_i high 3 cycles -> wdata/valid held stable, IDLE 1 cycle after stall drops;
//     EX_DIV_EN off: DIVU 9/3 -> ex_illegal_o=1, we=0, busy never asserted.

Source files
------------

// File: rtl/ex_mc_stage_pkg.sv
// ex_mc_stage_pkg: op codes, FSM states and op-class helpers for the multi-cycle EX stage
package ex_mc_stage_pkg;
  typedef enum logic [4:0] {
    ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_AND = 5'd2, ALU_OR = 5'd3, ALU_XOR = 5'd4, ALU_NAND = 5'd5,
    ALU_SLL = 5'd6, ALU_SRL = 5'd7, ALU_SRA = 5'd8, ALU_SLT = 5'd9, ALU_SLTU = 5'd10,
    ALU_EQ = 5'd11, ALU_NE = 5'd12, ALU_GE = 5'd13, ALU_GEU = 5'd14, ALU_NOP = 5'd15,
    ALU_MUL = 5'd16, ALU_MULH = 5'd17, ALU_MULHSU = 5'd18, ALU_MULHU = 5'd19,
    ALU_DIV = 5'd20, ALU_DIVU = 5'd21, ALU_REM = 5'd22, ALU_REMU = 5'd23
  } alu_op_e;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} ex_state_e;
  function automatic logic is_mdu(input logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction
  function automatic logic is_div(input logic [4:0] op);
    return is_mdu(op) && op[2];
  endfunction
endpackage

// File: rtl/ex_mc_stage_if.sv
// ex_mc_stage_if: ID/EX-to-EX/MEM bus plus flow-control lines; master = pipeline side, slave = EX stage
interface ex_mc_stage_if #(parameter int XLEN = 32);
  logic idex_valid, idex_reg_we, idex_btype_flag, idex_mtype, idex_mem_rw, fc_stall_ex, fc_flush_ex;
  logic [XLEN-1:0] idex_op_a, idex_op_b, idex_btype_jump_pc, idex_mem_wr_data;
  logic [4:0] idex_alu_ctrl, idex_reg_waddr;
  logic [1:0] idex_mem_width;
  logic ex_valid, ex_busy, ex_reg_we, ex_branch_flag, ex_req_dcache, ex_mem_rw, ex_illegal;
  logic [XLEN-1:0] ex_reg_wdata, ex_branch_pc, ex_mem_addr, ex_mem_wr_data;
  logic [4:0] ex_reg_waddr;
  logic [1:0] ex_mem_width;
  modport master (
    output idex_valid, idex_reg_we, idex_btype_flag, idex_mtype, idex_mem_rw, fc_stall_ex, fc_flush_ex,
           idex_op_a, idex_op_b, idex_btype_jump_pc, idex_mem_wr_data, idex_alu_ctrl, idex_reg_waddr, idex_mem_width,
    input  ex_valid, ex_busy, ex_reg_we, ex_branch_flag, ex_req_dcache, ex_mem_rw, ex_illegal,
           ex_reg_wdata, ex_branch_pc, ex_mem_addr, ex_mem_wr_data, ex_reg_waddr, ex_mem_width
  );
  modport slave (
    input  idex_valid, idex_reg_we, idex_btype_flag, idex_mtype, idex_mem_rw, fc_stall_ex, fc_flush_ex,
           idex_op_a, idex_op_b, idex_btype_jump_pc, idex_mem_wr_data, idex_alu_ctrl, idex_reg_waddr, idex_mem_width,
    output ex_valid, ex_busy, ex_reg_we, ex_branch_flag, ex_req_dcache, ex_mem_rw, ex_illegal,
           ex_reg_wdata, ex_branch_pc, ex_mem_addr, ex_mem_wr_data, ex_reg_waddr, ex_mem_width
  );
endinterface

// File: rtl/ex_mc_stage_mdu.sv
// ex_mc_stage_mdu: iterative shift-add multiplier and restoring divider working on operand magnitudes
// ports: clk, rst_n, start (load a/b/op), flush (abandon op), op[2:0] (MUL..REMU index), a, b,
//        last (final iteration this cycle), result (sign-corrected answer from the held registers)
// EX_DIV_EN: builds the divide iteration
module ex_mc_stage_mdu #(parameter int XLEN = 32, parameter int MUL_BITS_CYC = 4) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            last,
  output logic [XLEN-1:0] result
);
  localparam int N_MUL = XLEN / MUL_BITS_CYC;
  localparam int CW = $clog2(XLEN + 1);
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] m, mag_a, mag_b, q, r;
  logic [2*XLEN-1:0] acc, acc_mul, acc_next, prod;
  logic [XLEN+MUL_BITS_CYC-1:0] mul_sum;
  logic [2:0] op_q;
  logic neg_q, neg_r, sa, sb;
  assign sa = a[XLEN-1] & !(op inside {3'd3, 3'd5, 3'd7});
  assign sb = b[XLEN-1] & !(op inside {3'd2, 3'd3, 3'd5, 3'd7});
  assign mag_a = sa ? -a : a;
  assign mag_b = sb ? -b : b;
  // acc = {partial product, unretired multiplier bits}; each step adds m*digit on top and shifts right
  assign mul_sum = {{MUL_BITS_CYC{1'b0}}, acc[2*XLEN-1:XLEN]} +
                   ({{MUL_BITS_CYC{1'b0}}, m} * {{XLEN{1'b0}}, acc[MUL_BITS_CYC-1:0]});
  assign acc_mul = {mul_sum, acc[XLEN-1:MUL_BITS_CYC]};
`ifdef EX_DIV_EN
  // acc = {remainder, dividend shifting into quotient}; bit XLEN of diff is the borrow
  logic [XLEN:0] shifted, diff;
  assign shifted = acc[2*XLEN-1:XLEN-1];
  assign diff = shifted - {1'b0, m};
  assign acc_next = op_q[2] ? {diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0], acc[XLEN-2:0], !diff[XLEN]} : acc_mul;
`else
  assign acc_next = acc_mul;
`endif
  assign prod = neg_q ? -acc : acc;
  assign q = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign r = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  assign result = op_q == 3'd0 ? prod[XLEN-1:0] : !op_q[2] ? prod[2*XLEN-1:XLEN] : op_q[1] ? r : q;
  assign last = cnt == CW'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      m <= '0;
      acc <= '0;
      op_q <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (flush) cnt <= '0;
    else if (start) begin
      cnt <= op[2] ? CW'(XLEN) : CW'(N_MUL);
      m <= op[2] ? mag_b : mag_a;
      acc <= {{XLEN{1'b0}}, op[2] ? mag_a : mag_b};
      op_q <= op;
      neg_q <= sa ^ sb;
      neg_r <= sa;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      acc <= acc_next;
    end
endmodule

// File: rtl/ex_mc_stage.sv
// ex_mc_stage: multi-cycle execute stage (ALU, branch, memory address, iterative MUL/DIV)
// ports: clk, rst_n (async, active-low), bus (ex_mc_stage_if.slave: ID/EX inputs, fc stall/flush, EX outputs)
// EX_DIV_EN: enables DIV/DIVU/REM/REMU; otherwise they complete at once as illegal
module ex_mc_stage import ex_mc_stage_pkg::*; #(parameter int XLEN = 32, parameter int MUL_BITS_CYC = 4) (
  input logic clk,
  input logic rst_n,
  ex_mc_stage_if.slave bus
);
  localparam int SW = $clog2(XLEN);
  ex_state_e state;
  logic [XLEN-1:0] a, b, alu, mdu_result, spec_result;
  logic [4:0] op, waddr_q;
  logic [SW-1:0] sh;
  logic we_q, idle, run, mdu_op, div_op, quick, start, last, illegal;
  assign a = bus.idex_op_a;
  assign b = bus.idex_op_b;
  assign op = bus.idex_alu_ctrl;
  assign sh = b[SW-1:0];
  assign mdu_op = is_mdu(op);
  assign div_op = is_div(op);
  always_comb
    case (op)
      ALU_ADD:  alu = a + b;
      ALU_SUB:  alu = a - b;
      ALU_AND:  alu = a & b;
      ALU_OR:   alu = a | b;
      ALU_XOR:  alu = a ^ b;
      ALU_NAND: alu = ~(a & b);
      ALU_SLL:  alu = a << sh;
      ALU_SRL:  alu = a >> sh;
      ALU_SRA:  alu = $signed(a) >>> sh;
      ALU_SLT:  alu = XLEN'($signed(a) < $signed(b));
      ALU_SLTU: alu = XLEN'(a < b);
      ALU_EQ:   alu = XLEN'(a == b);
      ALU_NE:   alu = XLEN'(a != b);
      ALU_GE:   alu = XLEN'($signed(a) >= $signed(b));
      ALU_GEU:  alu = XLEN'(a >= b);
      default:  alu = '0;
    endcase
`ifdef EX_DIV_EN
  // divide-by-zero and MIN/-1 have fixed answers, so they never enter the iterative divider
  logic dz, ovf;
  assign dz = b == '0;
  assign ovf = !op[0] && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1;
  assign quick = div_op & (dz | ovf);
  assign spec_result = op[1] ? (dz ? a : '0) : (dz ? '1 : a);
  assign illegal = 1'b0;
`else
  assign quick = div_op;
  assign spec_result = '0;
  assign illegal = idle & bus.idex_valid & div_op;
`endif
  assign idle = state == S_IDLE;
  assign run = state == S_MUL || state == S_DIV;
  assign start = idle & bus.idex_valid & mdu_op & !quick & !bus.fc_stall_ex & !bus.fc_flush_ex;
  assign bus.ex_busy = run | (idle & bus.idex_valid & mdu_op & !quick);
  assign bus.ex_valid = idle ? bus.idex_valid & !(mdu_op & !quick) : state == S_DONE & !bus.fc_flush_ex;
  assign bus.ex_reg_wdata = state == S_DONE ? mdu_result : run ? '0 : quick ? spec_result : alu;
  assign bus.ex_reg_waddr = idle ? bus.idex_reg_waddr : waddr_q;
  assign bus.ex_reg_we = bus.ex_valid & (idle ? bus.idex_reg_we & !illegal : we_q);
  assign bus.ex_branch_flag = idle & bus.ex_valid & bus.idex_btype_flag & (bus.ex_reg_wdata != '0);
  assign bus.ex_branch_pc = bus.idex_btype_jump_pc;
  assign bus.ex_req_dcache = idle & bus.idex_valid & bus.idex_mtype & !bus.fc_stall_ex & !bus.fc_flush_ex;
  assign bus.ex_mem_addr = alu;
  assign bus.ex_mem_rw = bus.idex_mem_rw;
  assign bus.ex_mem_width = bus.idex_mem_width;
  assign bus.ex_mem_wr_data = bus.idex_mem_wr_data;
  assign bus.ex_illegal = illegal;
  ex_mc_stage_mdu #(.XLEN(XLEN), .MUL_BITS_CYC(MUL_BITS_CYC)) u_mdu (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(bus.fc_flush_ex), .op(op[2:0]),
    .a(a), .b(b), .last(last), .result(mdu_result)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      waddr_q <= '0;
      we_q <= 1'b0;
    end else
      case (state)
        S_IDLE: if (start) begin
          state <= div_op ? S_DIV : S_MUL;
          waddr_q <= bus.idex_reg_waddr;
          we_q <= bus.idex_reg_we;
        end
        S_MUL, S_DIV: state <= bus.fc_flush_ex ? S_IDLE : last ? S_DONE : state;
        default: if (bus.fc_flush_ex | !bus.fc_stall_ex) state <= S_IDLE;
      endcase
endmodule

// File: tb/tb_ex_mc_stage.sv
// tb_ex_mc_stage: randomized directed-step bench for ex_mc_stage against an arithmetic reference model
module tb_ex_mc_stage;
  import ex_mc_stage_pkg::*;
  logic clk = 1'b0, rst_n = 1'b1;
  int vectors = 0, miscompares = 0;
  ex_mc_stage_if #(.XLEN(32)) bus();
  ex_mc_stage #(.XLEN(32), .MUL_BITS_CYC(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a)), sb = longint'($signed(b));
    longint ua = longint'({32'b0, a}), ub = longint'({32'b0, b});
    logic ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    case (op)
      ALU_ADD:    return a + b;
      ALU_SUB:    return a - b;
      ALU_AND:    return a & b;
      ALU_OR:     return a | b;
      ALU_XOR:    return a ^ b;
      ALU_NAND:   return ~(a & b);
      ALU_SLL:    return a << b[4:0];
      ALU_SRL:    return a >> b[4:0];
      ALU_SRA:    return 32'(sa >>> b[4:0]);
      ALU_SLT:    return {31'b0, sa < sb};
      ALU_SLTU:   return {31'b0, ua < ub};
      ALU_EQ:     return {31'b0, a == b};
      ALU_NE:     return {31'b0, a != b};
      ALU_GE:     return {31'b0, sa >= sb};
      ALU_GEU:    return {31'b0, ua >= ub};
      ALU_MUL:    return 32'(sa * sb);
      ALU_MULH:   return 32'((sa * sb) >> 32);
      ALU_MULHSU: return 32'((sa * ub) >> 32);
      ALU_MULHU:  return 32'((ua * ub) >> 32);
      ALU_DIV:    return b == 0 ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      ALU_DIVU:   return b == 0 ? 32'hFFFF_FFFF : a / b;
      ALU_REM:    return b == 0 ? a : ovf ? 32'h0 : 32'(sa % sb);
      ALU_REMU:   return b == 0 ? a : a % b;
      default:    return 32'h0;
    endcase
  endfunction
  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa);
    bus.idex_valid = 1'b1;
    bus.idex_alu_ctrl = op;
    bus.idex_op_a = a;
    bus.idex_op_b = b;
    bus.idex_reg_waddr = wa;
    bus.idex_reg_we = 1'b1;
  endtask
  task automatic alu_step(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] wa = 5'($urandom);
    drive(op, a, b, wa);
    @(negedge clk);
    chk("alu_wdata", bus.ex_reg_wdata, ref_result(op, a, b));
    chk("alu_valid", {31'b0, bus.ex_valid}, 32'd1);
    chk("alu_busy", {31'b0, bus.ex_busy}, 32'd0);
    chk("alu_we", {31'b0, bus.ex_reg_we}, 32'd1);
    chk("alu_waddr", {27'b0, bus.ex_reg_waddr}, {27'b0, wa});
    @(posedge clk); #1 bus.idex_valid = 1'b0;
  endtask
  task automatic mdu_step(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    int lat = (op[2] ? 32 : 8) + 1;
    int n = 0;
    logic [31:0] exp = ref_result(op, a, b);
    logic [4:0] wa = 5'($urandom);
    drive(op, a, b, wa);
    @(negedge clk);
    chk("accept_busy", {31'b0, bus.ex_busy}, 32'd1);
    chk("accept_valid", {31'b0, bus.ex_valid}, 32'd0);
    @(posedge clk); #1 bus.idex_valid = 1'b0;
    bus.fc_stall_ex = hold > 0;
    do begin
      @(negedge clk);
      n++;
      if (!bus.ex_valid) chk("run_busy", {31'b0, bus.ex_busy}, 32'd1);
    end while (!bus.ex_valid && n < 40);
    chk("latency", 32'(n), 32'(lat));
    chk("mdu_wdata", bus.ex_reg_wdata, exp);
    chk("done_busy", {31'b0, bus.ex_busy}, 32'd0);
    chk("done_we", {31'b0, bus.ex_reg_we}, 32'd1);
    chk("done_waddr", {27'b0, bus.ex_reg_waddr}, {27'b0, wa});
    for (int k = 1; k < hold; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_valid", {31'b0, bus.ex_valid}, 32'd1);
      chk("hold_wdata", bus.ex_reg_wdata, exp);
    end
    if (hold > 0) begin
      @(posedge clk); #1 bus.fc_stall_ex = 1'b0;
      @(negedge clk);
      chk("release_valid", {31'b0, bus.ex_valid}, 32'd1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_valid", {31'b0, bus.ex_valid}, 32'd0);
    chk("idle_busy", {31'b0, bus.ex_busy}, 32'd0);
    @(posedge clk); #1;
  endtask
  initial begin
    {bus.idex_valid, bus.idex_reg_we, bus.idex_btype_flag, bus.idex_mtype, bus.idex_mem_rw} = '0;
    {bus.fc_stall_ex, bus.fc_flush_ex, bus.idex_mem_width, bus.idex_alu_ctrl, bus.idex_reg_waddr} = '0;
    {bus.idex_op_a, bus.idex_op_b, bus.idex_btype_jump_pc, bus.idex_mem_wr_data} = '0;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_valid", {31'b0, bus.ex_valid}, 32'd0);
    chk("rst_busy", {31'b0, bus.ex_busy}, 32'd0);
    chk("rst_req", {31'b0, bus.ex_req_dcache}, 32'd0);
    chk("rst_branch", {31'b0, bus.ex_branch_flag}, 32'd0);
    chk("rst_we", {31'b0, bus.ex_reg_we}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    alu_step(ALU_ADD, 32'd5, 32'd7);
    for (int i = 0; i < 16; i++) alu_step(5'($urandom_range(0, 15)), $urandom, $urandom);
    drive(ALU_EQ, 32'h1234, 32'h1234, 5'd1);
    bus.idex_btype_flag = 1'b1;
    bus.idex_btype_jump_pc = $urandom;
    @(negedge clk);
    chk("br_taken", {31'b0, bus.ex_branch_flag}, 32'd1);
    chk("br_pc", bus.ex_branch_pc, bus.idex_btype_jump_pc);
    bus.idex_alu_ctrl = ALU_NE;
    #1 chk("br_not_taken", {31'b0, bus.ex_branch_flag}, 32'd0);
    @(posedge clk); #1 {bus.idex_valid, bus.idex_btype_flag} = '0;
    drive(ALU_ADD, 32'h1000, 32'h24, 5'd2);
    bus.idex_mtype = 1'b1;
    bus.idex_mem_rw = 1'b1;
    bus.idex_mem_width = 2'd2;
    bus.idex_mem_wr_data = $urandom;
    @(negedge clk);
    chk("mem_req", {31'b0, bus.ex_req_dcache}, 32'd1);
    chk("mem_addr", bus.ex_mem_addr, 32'h1024);
    chk("mem_wdata", bus.ex_mem_wr_data, bus.idex_mem_wr_data);
    bus.fc_stall_ex = 1'b1;
    #1 chk("mem_req_stalled", {31'b0, bus.ex_req_dcache}, 32'd0);
    @(posedge clk); #1 {bus.idex_valid, bus.idex_mtype, bus.fc_stall_ex} = '0;
    mdu_step(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    mdu_step(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    for (int i = 0; i < 12; i++) mdu_step(5'(16 + $urandom_range(0, 3)), $urandom, $urandom, 0);
    mdu_step(ALU_MULHSU, $urandom, $urandom, 3);
    drive(ALU_MUL, $urandom, $urandom, 5'd3);
    @(posedge clk); #1 bus.idex_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 bus.fc_flush_ex = 1'b1;
    @(posedge clk); #1 bus.fc_flush_ex = 1'b0;
    @(negedge clk);
    chk("flush_busy", {31'b0, bus.ex_busy}, 32'd0);
    chk("flush_valid", {31'b0, bus.ex_valid}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("flush_no_result", {31'b0, bus.ex_valid}, 32'd0);
    end
    @(posedge clk); #1;
    alu_step(ALU_ADD, $urandom, $urandom);
    drive(ALU_MULH, $urandom, $urandom, 5'd4);
    @(posedge clk); #1 bus.idex_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b0;
    #1 chk("async_rst_busy", {31'b0, bus.ex_busy}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("rst_no_result", {31'b0, bus.ex_valid}, 32'd0);
    end
    @(posedge clk); #1;
`ifdef EX_DIV_EN
    mdu_step(ALU_DIV, -32'sd7, 32'd2, 0);
    mdu_step(ALU_REM, -32'sd7, 32'd2, 0);
    mdu_step(ALU_DIVU, 32'd100, 32'd7, 0);
    alu_step(ALU_DIV, 32'd10, 32'd0);
    alu_step(ALU_REM, 32'd10, 32'd0);
    alu_step(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    alu_step(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++) mdu_step(5'(20 + $urandom_range(0, 3)), $urandom, $urandom | 32'd1, 0);
`else
    for (int i = 0; i < 3; i++) begin
      logic [4:0] op = i == 0 ? 5'(ALU_DIVU) : 5'(20 + $urandom_range(0, 3));
      drive(op, i == 0 ? 32'd9 : $urandom, i == 0 ? 32'd3 : $urandom, 5'd5);
      @(negedge clk);
      chk("ill_flag", {31'b0, bus.ex_illegal}, 32'd1);
      chk("ill_we", {31'b0, bus.ex_reg_we}, 32'd0);
      chk("ill_busy", {31'b0, bus.ex_busy}, 32'd0);
      chk("ill_valid", {31'b0, bus.ex_valid}, 32'd1);
      chk("ill_wdata", bus.ex_reg_wdata, 32'd0);
      @(posedge clk); #1 bus.idex_valid = 1'b0;
      @(negedge clk);
      chk("ill_after_busy", {31'b0, bus.ex_busy}, 32'd0);
      chk("ill_after_flag", {31'b0, bus.ex_illegal}, 32'd0);
      @(posedge clk); #1;
    end
`endif
    mdu_step(ALU_MUL, $urandom, $urandom, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
